// File: rtl/ram_pkg.sv
// Shared sizing and word type for the scratch RAM and neighbouring datapath blocks.
package ram_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_design.sv
// Single-port 16 x 8 flip-flop register-file RAM.
// Writes are stored at the sampling edge, and reads come back registered one cycle later.
// Writes never update r_data, because there is no write-through.
module ram_design
    import ram_pkg::*;
#(
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  wordWrEn;
    logic              readReq;
    logic [DATA_W-1:0] rData_q;
    logic [DATA_W-1:0] rData_d;

    assign readReq = cs && !wen;

    // Write decode: one-hot enable selecting the single word a qualified write targets.
    always_comb begin
        wordWrEn = '0;
        if (cs && wen) begin
            wordWrEn[addr] = 1'b1;
        end
    end

    // Next-state of the array: only the decoded word takes w_data, and every other word holds.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wordWrEn[i]) begin
                mem_d[i] = w_data;
            end
        end
    end

    // Storage array: reset clears every word at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read mux: capture the addressed word on a read, otherwise hold the last value read.
    always_comb begin
        rData_d = rData_q;
        if (readReq) begin
            rData_d = mem_q[addr];
        end
    end

    // Registered read data, cleared asynchronously with the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rData_q <= '0;
        end else begin
            rData_q <= rData_d;
        end
    end

    assign r_data = rData_q;

endmodule : ram_design

// File: tb/tb_ram_design.sv
// Self-checking bench for ram_design: directed steps followed by random traffic, checked against an array model.
module tb_ram_design;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              cs;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    // Behavioural model: plain array contents plus the last value a read returned.
    logic [DATA_W-1:0] modelMem [DEPTH];
    logic [DATA_W-1:0] modelRData;

    int checkCount = 0;
    int failCount  = 0;

    ram_design #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (cs),
        .wen   (wen),
        .addr  (addr),
        .w_data(w_data),
        .r_data(r_data)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always ends, even if the stimulus gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clear the model the way a reset clears the RAM.
    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        modelRData = '0;
    endtask

    // Drive one request on the falling edge, let the rising edge sample it, then update the model.
    task automatic applyStimulus(input logic c, input logic w,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        cs     = c;
        wen    = w;
        addr   = a;
        w_data = d;
        @(posedge clk);
        #1;
        if (c && w)  modelMem[a] = d;
        else if (c)  modelRData  = modelMem[a];
    endtask

    // Compare r_data against an expected value.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] expected);
        checkCount++;
        assert (r_data === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: r_data=%h expected=%h", tag, r_data, expected);
        end
    endtask

    // Directed test plan first, then random traffic against the model.
    initial begin
        logic [DATA_W-1:0] fillVals [9];
        fillVals = '{8'hAA, 8'h0F, 8'hCC, 8'h1F, 8'h17, 8'hDF, 8'h11, 8'h1D, 8'h03};

        cs = 1'b0; wen = 1'b0; addr = '0; w_data = '0;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rdata", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset contents");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(a), 8'h5A);
            checkOutput("reset_read", 8'h00);
        end

        $display("[TB] fill and read back");
        for (int a = 0; a < 9; a++) begin
            applyStimulus(1'b1, 1'b1, ADDR_W'(a), fillVals[a]);
            checkOutput("fill_no_through", 8'h00);
        end
        for (int a = 0; a < 9; a++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(a), 8'h00);
            checkOutput("fill_read", fillVals[a]);
        end

        $display("[TB] idle hold");
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h00);
        checkOutput("idle_pre_read", 8'hCC);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd5, 8'hEE);
            checkOutput("idle_hold", 8'hCC);
        end
        applyStimulus(1'b1, 1'b0, 4'd5, 8'h00);
        checkOutput("idle_mem_unchanged", 8'hDF);

        $display("[TB] write without write-through");
        applyStimulus(1'b1, 1'b0, 4'd1, 8'h00);
        checkOutput("wnt_read1", 8'h0F);
        applyStimulus(1'b1, 1'b1, 4'd3, 8'h55);
        checkOutput("wnt_hold", 8'h0F);
        applyStimulus(1'b1, 1'b0, 4'd3, 8'h00);
        checkOutput("wnt_read3", 8'h55);

        $display("[TB] address boundaries");
        applyStimulus(1'b1, 1'b1, 4'd15, 8'hF0);
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h0A);
        applyStimulus(1'b1, 1'b0, 4'd15, 8'h00);
        checkOutput("bound_read15", 8'hF0);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00);
        checkOutput("bound_read0", 8'h0A);

        $display("[TB] asynchronous reset between edges");
        @(negedge clk);
        cs = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset_now", 8'h00);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00);
        checkOutput("async_reset_read0", 8'h00);
        applyStimulus(1'b1, 1'b0, 4'd8, 8'h00);
        checkOutput("async_reset_read8", 8'h00);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic              rc;
            logic              rw;
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            rc = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1) == 1;
            ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd = DATA_W'($urandom);
            applyStimulus(rc, rw, ra, rd);
            checkOutput("random", modelRData);
        end

        $display("[TB] final sweep");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 1'b0, ADDR_W'(a), 8'h00);
            checkOutput("sweep", modelRData);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule : tb_ram_design
